// File: rtl/i2c_route_ctrl.sv
// I2C slave configuration controller for the TDM routing fabric.
// Holds the per-slot route-select registers and a read-only ID byte behind a pointer-addressed register map.
module i2c_route_ctrl #(
   parameter logic [6:0]             DEV_ADDR      = 7'h3A,
   parameter int                     NUM_ROUTE     = 4,
   parameter logic [7:0]             ID_VALUE      = 8'hA1,
   parameter logic [8*NUM_ROUTE-1:0] ROUTE_DEFAULT = 32'h03020100
) (
   input  logic                     clkin,
   input  logic                     nrst,
   input  logic                     scl,
   input  logic                     sda_in,
   output logic                     sda_oe,
   output logic [8*NUM_ROUTE-1:0]   route_cfg,
   output logic                     cfg_update,
   output logic                     busy
);

   localparam int         IDX_W    = (NUM_ROUTE > 1) ? $clog2(NUM_ROUTE) : 1;
   localparam logic [7:0] NUM_ROUTE_B = 8'(NUM_ROUTE);

   typedef enum logic [3:0] {
      S_IDLE, S_ADDR, S_ADDR_ACK, S_PTR, S_PTR_ACK,
      S_WDATA, S_WDATA_ACK, S_RDATA, S_RDATA_ACK, S_IGNORE
   } state_t;

   state_t      state_q, state_d;
   logic [3:0]  bit_cnt_q, bit_cnt_d;
   logic [7:0]  sr_q, sr_d;
   logic [7:0]  ptr_q, ptr_d;
   logic        sda_oe_d, busy_d, got_ack_q, got_ack_d, wr_en;
   logic [7:0]  regs [NUM_ROUTE];
   logic [7:0]  rd_byte;

   logic scl_s1, scl_s2, scl_d, sda_s1, sda_s2, sda_d;
   logic scl_rise, scl_fall, start_det, stop_det;

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clkin or negedge nrst) begin
      if (!nrst) begin
         {scl_s1, scl_s2, scl_d} <= 3'b111;
         {sda_s1, sda_s2, sda_d} <= 3'b111;
      end else begin
         {scl_s1, scl_s2, scl_d} <= {scl, scl_s1, scl_s2};
         {sda_s1, sda_s2, sda_d} <= {sda_in, sda_s1, sda_s2};
      end
   end

   assign scl_rise  =  scl_s2 & ~scl_d;
   assign scl_fall  = ~scl_s2 &  scl_d;
   assign start_det =  scl_s2 &  scl_d &  sda_d & ~sda_s2;
   assign stop_det  =  scl_s2 &  scl_d & ~sda_d &  sda_s2;

   always_comb begin
      if (ptr_q < NUM_ROUTE_B)       rd_byte = regs[ptr_q[IDX_W-1:0]];
      else if (ptr_q == NUM_ROUTE_B) rd_byte = ID_VALUE;
      else                           rd_byte = 8'h00;
   end

   // NOTE: every combinational output gets a default first so no path can infer a latch.
   always_comb begin
      state_d   = state_q;
      bit_cnt_d = bit_cnt_q;
      sr_d      = sr_q;
      ptr_d     = ptr_q;
      sda_oe_d  = sda_oe;
      busy_d    = busy;
      got_ack_d = got_ack_q;
      wr_en     = 1'b0;
      if (start_det) begin
         state_d   = S_ADDR;
         bit_cnt_d = 4'd0;
         sda_oe_d  = 1'b0;
      end else if (stop_det) begin
         state_d  = S_IDLE;
         sda_oe_d = 1'b0;
         busy_d   = 1'b0;
      end else begin
         unique case (state_q)
            S_ADDR, S_PTR, S_WDATA: begin
               if (scl_rise && bit_cnt_q != 4'd8) begin
                  sr_d      = {sr_q[6:0], sda_s2};
                  bit_cnt_d = bit_cnt_q + 4'd1;
               end else if (scl_fall && bit_cnt_q == 4'd8) begin
                  bit_cnt_d = 4'd0;
                  sda_oe_d  = 1'b1;
                  if (state_q == S_ADDR) begin
                     if (sr_q[7:1] == DEV_ADDR) begin
                        state_d = S_ADDR_ACK;
                        busy_d  = 1'b1;
                     end else begin
                        state_d  = S_IGNORE;
                        sda_oe_d = 1'b0;
                        busy_d   = 1'b0;
                     end
                  end else if (state_q == S_PTR) begin
                     ptr_d   = sr_q;
                     state_d = S_PTR_ACK;
                  end else begin
                     wr_en   = (ptr_q < NUM_ROUTE_B);
                     ptr_d   = ptr_q + 8'd1;
                     state_d = S_WDATA_ACK;
                  end
               end
            end
            S_ADDR_ACK: if (scl_fall) begin
               bit_cnt_d = 4'd0;
               if (sr_q[0]) begin
                  sr_d     = rd_byte;
                  sda_oe_d = ~rd_byte[7];
                  state_d  = S_RDATA;
               end else begin
                  sda_oe_d = 1'b0;
                  state_d  = S_PTR;
               end
            end
            S_PTR_ACK, S_WDATA_ACK: if (scl_fall) begin
               sda_oe_d = 1'b0;
               state_d  = S_WDATA;
            end
            S_RDATA: if (scl_fall) begin
               if (bit_cnt_q == 4'd7) begin
                  bit_cnt_d = 4'd0;
                  sda_oe_d  = 1'b0;
                  got_ack_d = 1'b0;
                  state_d   = S_RDATA_ACK;
               end else begin
                  bit_cnt_d = bit_cnt_q + 4'd1;
                  sr_d      = {sr_q[6:0], 1'b0};
                  sda_oe_d  = ~sr_q[6];
               end
            end
            S_RDATA_ACK: begin
               if (scl_rise) begin
                  if (sda_s2) state_d = S_IGNORE;
                  else begin
                     got_ack_d = 1'b1;
                     ptr_d     = ptr_q + 8'd1;
                  end
               end else if (scl_fall && got_ack_q) begin
                  sr_d     = rd_byte;
                  sda_oe_d = ~rd_byte[7];
                  state_d  = S_RDATA;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clkin or negedge nrst) begin
      if (!nrst) begin
         state_q    <= S_IDLE;
         bit_cnt_q  <= 4'd0;
         sr_q       <= 8'h00;
         ptr_q      <= 8'h00;
         sda_oe     <= 1'b0;
         busy       <= 1'b0;
         got_ack_q  <= 1'b0;
         cfg_update <= 1'b0;
      end else begin
         state_q    <= state_d;
         bit_cnt_q  <= bit_cnt_d;
         sr_q       <= sr_d;
         ptr_q      <= ptr_d;
         sda_oe     <= sda_oe_d;
         busy       <= busy_d;
         got_ack_q  <= got_ack_d;
         cfg_update <= wr_en;
      end
   end

   // NOTE: the register file is small and needs a defined routing at power-up, so it is reset like ordinary flops.
   always_ff @(posedge clkin or negedge nrst) begin
      if (!nrst) begin
         for (int i = 0; i < NUM_ROUTE; i++) regs[i] <= ROUTE_DEFAULT[8*i +: 8];
      end else if (wr_en) begin
         regs[ptr_q[IDX_W-1:0]] <= sr_q;
      end
   end

   for (genvar g = 0; g < NUM_ROUTE; g++) begin : g_route
      assign route_cfg[8*g +: 8] = regs[g];
   end

endmodule

// File: tb/tb_i2c_route_ctrl.sv
// Directed bench for i2c_route_ctrl: a bit-banged I2C master on a wired-AND SDA line,
// checking ACKs, read data, route registers and cfg_update pulse counts.
module tb_i2c_route_ctrl;

   localparam time Q = 100ns;

   logic        clkin = 1'b0;
   logic        nrst;
   logic        scl;
   logic        master_sda;
   logic        sda_line;
   logic        sda_oe;
   logic [31:0] route_cfg;
   logic        cfg_update;
   logic        busy;

   int tests_run    = 0;
   int tests_failed = 0;
   int upd_cnt      = 0;

   assign sda_line = master_sda & ~sda_oe;

   i2c_route_ctrl dut (
      .clkin      (clkin),
      .nrst       (nrst),
      .scl        (scl),
      .sda_in     (sda_line),
      .sda_oe     (sda_oe),
      .route_cfg  (route_cfg),
      .cfg_update (cfg_update),
      .busy       (busy)
   );

   always #5ns clkin = ~clkin;

   always @(posedge clkin) if (cfg_update) upd_cnt++;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests_run++;
      assert (obs === exp) else begin
         tests_failed++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic i2c_start();
      master_sda = 1'b1; #Q;
      scl = 1'b1;        #Q;
      master_sda = 1'b0; #Q;
      scl = 1'b0;        #Q;
   endtask

   task automatic i2c_stop();
      master_sda = 1'b0; #Q;
      scl = 1'b1;        #Q;
      master_sda = 1'b1; #Q;
   endtask

   task automatic write_bit(input logic b);
      master_sda = b; #Q;
      scl = 1'b1;     #(2*Q);
      scl = 1'b0;     #Q;
   endtask

   task automatic read_bit(output logic b);
      master_sda = 1'b1; #Q;
      scl = 1'b1;        #Q;
      b = sda_line;      #Q;
      scl = 1'b0;        #Q;
   endtask

   task automatic write_byte(input logic [7:0] d, output logic ack);
      for (int i = 7; i >= 0; i--) write_bit(d[i]);
      read_bit(ack);
   endtask

   task automatic read_byte(input logic ack_bit, output logic [7:0] d);
      logic b;
      for (int i = 7; i >= 0; i--) begin
         read_bit(b);
         d[i] = b;
      end
      write_bit(ack_bit);
      master_sda = 1'b1;
   endtask

   initial begin
      logic       ack;
      logic [7:0] rd;

      nrst = 1'b0; scl = 1'b1; master_sda = 1'b1;
      #52ns;
      check("reset_route", route_cfg, 32'h03020100);
      check("reset_sda_oe", {31'd0, sda_oe}, 32'd0);
      check("reset_busy", {31'd0, busy}, 32'd0);
      check("reset_cfg_update", {31'd0, cfg_update}, 32'd0);
      nrst = 1'b1; #Q;

      // Pointer 0x02 then repeated START and read three bytes.
      i2c_start();
      write_byte(8'h74, ack); check("rd_addr_w_ack", {31'd0, ack}, 32'd0);
      check("rd_busy", {31'd0, busy}, 32'd1);
      write_byte(8'h02, ack); check("rd_ptr_ack", {31'd0, ack}, 32'd0);
      i2c_start();
      write_byte(8'h75, ack); check("rd_addr_r_ack", {31'd0, ack}, 32'd0);
      read_byte(1'b0, rd); check("rd_byte0", {24'd0, rd}, 32'h02);
      read_byte(1'b0, rd); check("rd_byte1", {24'd0, rd}, 32'h03);
      read_byte(1'b1, rd); check("rd_byte2_id", {24'd0, rd}, 32'hA1);
      check("rd_release_after_nack", {31'd0, sda_oe}, 32'd0);
      i2c_stop();
      check("rd_busy_after_stop", {31'd0, busy}, 32'd0);

      // Burst write starting at pointer 1.
      upd_cnt = 0;
      i2c_start();
      write_byte(8'h74, ack); check("wr_addr_ack", {31'd0, ack}, 32'd0);
      write_byte(8'h01, ack); check("wr_ptr_ack", {31'd0, ack}, 32'd0);
      write_byte(8'h05, ack); check("wr_d0_ack", {31'd0, ack}, 32'd0);
      write_byte(8'h07, ack); check("wr_d1_ack", {31'd0, ack}, 32'd0);
      i2c_stop();
      check("wr_route", route_cfg, 32'h03070500);
      check("wr_upd_cnt", upd_cnt, 32'd2);

      // Foreign address is ignored, bus stays idle.
      upd_cnt = 0;
      i2c_start();
      write_byte(8'hA0, ack); check("foreign_nack", {31'd0, ack}, 32'd1);
      check("foreign_busy", {31'd0, busy}, 32'd0);
      write_byte(8'h00, ack); check("foreign_data_nack", {31'd0, ack}, 32'd1);
      i2c_stop();
      check("foreign_route", route_cfg, 32'h03070500);

      // Pointer wrap: 0xFF discarded, then register 0 written.
      i2c_start();
      write_byte(8'h74, ack); check("wrap_addr_ack", {31'd0, ack}, 32'd0);
      write_byte(8'hFF, ack); check("wrap_ptr_ack", {31'd0, ack}, 32'd0);
      write_byte(8'h11, ack); check("wrap_d0_ack", {31'd0, ack}, 32'd0);
      write_byte(8'h22, ack); check("wrap_d1_ack", {31'd0, ack}, 32'd0);
      i2c_stop();
      check("wrap_route", route_cfg, 32'h03070522);
      check("wrap_upd_cnt", upd_cnt, 32'd1);

      // STOP after half a data byte discards it.
      upd_cnt = 0;
      i2c_start();
      write_byte(8'h74, ack);
      write_byte(8'h03, ack);
      for (int i = 0; i < 4; i++) write_bit(1'b1);
      i2c_stop();
      check("abort_upd_cnt", upd_cnt, 32'd0);
      check("abort_busy", {31'd0, busy}, 32'd0);
      check("abort_route", route_cfg, 32'h03070522);
      i2c_start();
      write_byte(8'h74, ack); check("post_abort_addr_ack", {31'd0, ack}, 32'd0);
      write_byte(8'h03, ack);
      write_byte(8'h44, ack); check("post_abort_d_ack", {31'd0, ack}, 32'd0);
      i2c_stop();
      check("post_abort_route", route_cfg, 32'h44070522);
      check("post_abort_upd_cnt", upd_cnt, 32'd1);

      // Reset mid data byte restores defaults.
      i2c_start();
      write_byte(8'h74, ack);
      write_byte(8'h00, ack);
      for (int i = 0; i < 4; i++) write_bit(1'b1);
      nrst = 1'b0; #1ns;
      check("midbyte_rst_route", route_cfg, 32'h03020100);
      check("midbyte_rst_sda_oe", {31'd0, sda_oe}, 32'd0);
      scl = 1'b1; master_sda = 1'b1; #Q;
      nrst = 1'b1; #Q;

      // Reset while the address ACK is being driven releases SDA at once.
      i2c_start();
      for (int i = 7; i >= 0; i--) write_bit(i == 0 ? 1'b0 : DEV_BITS(i));
      check("ack_phase_sda_oe", {31'd0, sda_oe}, 32'd1);
      nrst = 1'b0; #1ns;
      check("ack_rst_sda_oe", {31'd0, sda_oe}, 32'd0);
      check("ack_rst_busy", {31'd0, busy}, 32'd0);
      scl = 1'b1; master_sda = 1'b1; #Q;
      nrst = 1'b1; #Q;

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

   // Bit i (7..1) of the write-address byte for device 0x3A.
   function automatic logic DEV_BITS(input int i);
      logic [7:0] a;
      a = 8'h74;
      return a[i];
   endfunction

endmodule
